// File: rtl/mux8_2_sched_if.sv
// Bus bundle between the eight sources / two lane consumers and mux8_2_sched.
// master: sources and lane consumers; slave: the scheduler.
interface mux8_2_sched_if #(
    parameter int unsigned W = 8
);
    logic           en;
    logic [7:0]     req;
    logic [8*W-1:0] ins;
    logic [7:0]     gnt;
    logic [W-1:0]   out0;
    logic [W-1:0]   out1;
    logic [1:0]     vld;
    logic [1:0]     rdy;
    logic [2:0]     setin0;
    logic [2:0]     setin1;
    logic           busy;

    modport master (
        output en, req, ins, rdy,
        input  gnt, out0, out1, vld, setin0, setin1, busy
    );

    modport slave (
        input  en, req, ins, rdy,
        output gnt, out0, out1, vld, setin0, setin1, busy
    );
endinterface

// File: rtl/mux8_2_sched.sv
// Round-robin scheduler sharing two registered, back-pressured W-bit lanes among eight sources.
// Optional MUX8_2_SCHED_TRISTATE_IDLE_EN: idle lanes drive all-z on their data outputs.
module mux8_2_sched #(
    parameter int unsigned W = 8
) (
    input logic            clk,
    input logic            rst_n,
    mux8_2_sched_if.slave  bus
);
    typedef enum logic {StIdle, StFull} lane_st_e;

    lane_st_e     lane_q [2];
    lane_st_e     lane_d [2];
    logic [W-1:0] data_q [2];
    logic [2:0]   src_q  [2];
    logic [2:0]   ptr_q, ptr_d;

    logic [1:0]   vld;
    logic [1:0]   free;
    logic [1:0]   grant;
    logic [2:0]   sel    [2];
    logic [W-1:0] din    [2];
    logic [7:0]   gnt_c;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            vld[k]  = (lane_q[k] == StFull);
            // A full lane being drained this edge can be refilled on the same edge.
            free[k] = !vld[k] || bus.rdy[k];
        end
    end

    // Scan from ptr_q; first hit takes the lowest free lane, second hit only if both are free.
    always_comb begin
        logic [2:0] idx;
        logic [2:0] last;
        logic [1:0] n;
        gnt_c  = '0;
        grant  = '0;
        sel[0] = '0;
        sel[1] = '0;
        last   = ptr_q;
        n      = '0;
        idx    = '0;
        if (bus.en && (free != 2'b00)) begin
            for (int j = 0; j < 8; j++) begin
                idx = ptr_q + 3'(j);
                if (bus.req[idx]) begin
                    if (n == 2'd0) begin
                        if (free[0]) begin
                            grant[0] = 1'b1;
                            sel[0]   = idx;
                        end else begin
                            grant[1] = 1'b1;
                            sel[1]   = idx;
                        end
                        gnt_c[idx] = 1'b1;
                        last       = idx;
                        n          = 2'd1;
                    end else if (n == 2'd1 && free == 2'b11) begin
                        grant[1]   = 1'b1;
                        sel[1]     = idx;
                        gnt_c[idx] = 1'b1;
                        last       = idx;
                        n          = 2'd2;
                    end
                end
            end
        end
        ptr_d = (gnt_c != '0) ? last + 3'd1 : ptr_q;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            din[k]    = bus.ins[sel[k]*W +: W];
            lane_d[k] = lane_q[k];
            if (grant[k]) begin
                lane_d[k] = StFull;
            end else if (vld[k] && bus.rdy[k]) begin
                lane_d[k] = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int k = 0; k < 2; k++) begin
                lane_q[k] <= StIdle;
                data_q[k] <= '0;
                src_q[k]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int k = 0; k < 2; k++) begin
                lane_q[k] <= lane_d[k];
                if (grant[k]) begin
                    data_q[k] <= din[k];
                    src_q[k]  <= sel[k];
                end
            end
        end
    end

    // Reset must silence grants immediately, even with en and req high.
    assign bus.gnt    = rst_n ? gnt_c : '0;
    assign bus.vld    = vld;
    assign bus.busy   = vld[0] | vld[1];
    assign bus.setin0 = src_q[0];
    assign bus.setin1 = src_q[1];

`ifdef MUX8_2_SCHED_TRISTATE_IDLE_EN
    assign bus.out0 = vld[0] ? data_q[0] : {W{1'bz}};
    assign bus.out1 = vld[1] ? data_q[1] : {W{1'bz}};
`else
    assign bus.out0 = data_q[0];
    assign bus.out1 = data_q[1];
`endif
endmodule
